// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the integer register file slice.
//
// The legacy defines (`RegBus, `RegAddrBus, `ZeroWord, `WriteEnable,
// `WriteDisable, `ReadEnable, `ReadDisable, `RegNum, `RegNumLog2) are kept
// here for code that still spells widths with them. New code uses the
// localparams below.
//
// Optional feature macro: REGFILE_WRITE_CNT_EN (consumed by regfile.sv).
// ---------------------------------------------------------------------------
`ifndef REGFILE_DEFINES_DONE
`define REGFILE_DEFINES_DONE
`define RegBus       31:0
`define RegAddrBus   4:0
`define ZeroWord     32'h0000_0000
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`define ReadEnable   1'b1
`define ReadDisable  1'b0
`define RegNum       32
`define RegNumLog2   5
`endif

package regfile_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

    localparam logic [RF_DATA_W-1:0] RF_ZERO_WORD = '0;

endpackage : regfile_pkg

// File: rtl/regfile_if.sv
// ---------------------------------------------------------------------------
// regfile_if
// Bundles the writeback bus (we/waddr/wdata) and the two decode-side read
// ports (reN/raddrN/rdataN) of the register file.
//
// Modports:
//   master - pipeline side: drives write bus and read requests, gets rdata.
//   slave  - register file side: consumes requests, drives rdata1/rdata2.
// ---------------------------------------------------------------------------
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;

    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );

endinterface : regfile_if

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// Combinational read-priority mux for one register-file read port.
//
// Ports:
//   rst   in  active-low reset (0 forces the output to zero)
//   re    in  read enable
//   raddr in  read index
//   we    in  writeback write enable
//   waddr in  writeback index
//   wdata in  writeback data (bypassed when it targets raddr)
//   word  in  array entry currently selected by raddr
//   rdata out read result
// ---------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        // NOTE: a default on entry to every always_comb path keeps the mux
        // purely combinational; a missing else would otherwise infer a latch.
        rdata = RF_ZERO_WORD;
        if (!rst || !re || raddr == '0) begin
            rdata = RF_ZERO_WORD;
        end else if (we && waddr == raddr) begin
            // Same-cycle writeback is forwarded so decode never sees stale data.
            rdata = wdata;
        end else begin
            rdata = word;
        end
    end

endmodule : regfile_read_port

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 32 x 32-bit integer register file, x0 hardwired to zero. One write port
// fed by the MEM/WB register, two combinational read ports feeding ID, with
// write-to-read bypass.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset, clears every entry
//   bus      --   regfile_if.slave: we/waddr/wdata, re1/raddr1/rdata1,
//                 re2/raddr2/rdata2
//   wr_count out  committed-write counter (only with REGFILE_WRITE_CNT_EN)
//
// Optional feature macro: REGFILE_WRITE_CNT_EN.
// ---------------------------------------------------------------------------
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic        clk,
    input  logic        rst,
    regfile_if.slave    bus
`ifdef REGFILE_WRITE_CNT_EN
    ,
    output logic [31:0] wr_count
`endif
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wr_commit;

    // Entry 0 is never written, so it holds its reset value of zero forever.
    assign w_wr_commit = bus.we && (bus.waddr != '0);

    // NOTE: the array is reset explicitly because every entry must read zero
    // right after rst, which also rules out mapping it onto a plain SRAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_commit) begin
            // NOTE: non-blocking so every reader in this time step sees the
            // pre-edge value of the array.
            r_regs[bus.waddr] <= bus.wdata;
        end
    end

`ifdef REGFILE_WRITE_CNT_EN
    logic [31:0] r_wr_count;

    // Counts only committed writes; wraps naturally at 2**32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_count <= '0;
        end else if (w_wr_commit) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign wr_count = r_wr_count;
`endif

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port1 (
        .rst   (rst),
        .re    (bus.re1),
        .raddr (bus.raddr1),
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .word  (r_regs[bus.raddr1]),
        .rdata (bus.rdata1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port2 (
        .rst   (rst),
        .re    (bus.re2),
        .raddr (bus.raddr2),
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .word  (r_regs[bus.raddr2]),
        .rdata (bus.rdata2)
    );

endmodule : regfile

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile
// Self-checking bench for regfile. A behavioural model (plain array plus a
// write count) tracks architectural state; reads are predicted from the
// read-priority rules. Build with +define+REGFILE_WRITE_CNT_EN to also cover
// wr_count.
// ---------------------------------------------------------------------------
module tb_regfile;
    import regfile_pkg::*;

    logic clk;
    logic rst;

    regfile_if #(.DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W)) bus ();

`ifdef REGFILE_WRITE_CNT_EN
    logic [31:0] wr_count;
`endif

    regfile dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef REGFILE_WRITE_CNT_EN
        ,
        .wr_count (wr_count)
`endif
    );

    logic [31:0] model [32];
    logic [31:0] model_cnt;
    int          checks;
    int          errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model_cnt = 32'h0;
    endfunction

    // Expected read value from the architectural rules.
    function automatic logic [31:0] expect_rd(logic en, logic [4:0] a);
        if (rst !== 1'b1 || en !== 1'b1 || a == 5'd0) return 32'h0;
        if (bus.we === 1'b1 && bus.waddr == a) return bus.wdata;
        return model[a];
    endfunction

    // Advance one rising edge, committing the presented write to the model.
    task automatic tick();
        @(posedge clk);
        if (rst === 1'b1 && bus.we === 1'b1 && bus.waddr != 5'd0) begin
            model[bus.waddr] = bus.wdata;
            model_cnt        = model_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] waddr,
                         input logic [31:0] wdata,
                         input logic re1, input logic [4:0] raddr1,
                         input logic re2, input logic [4:0] raddr2);
        bus.we     = we;
        bus.waddr  = waddr;
        bus.wdata  = wdata;
        bus.re1    = re1;
        bus.raddr1 = raddr1;
        bus.re2    = re2;
        bus.raddr2 = raddr2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        // A write held during reset must be dropped.
        drive(1'b1, 5'd5, 32'hCAFE_F00D, 1'b1, 5'd0, 1'b1, 5'd0);
        repeat (3) tick();
        for (int i = 0; i < 32; i++) begin
            bus.raddr1 = 5'(i);
            bus.raddr2 = 5'(31 - i);
            #1;
            checks++;
            if (bus.rdata1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd1[%0d]: got %h expected 00000000", i, bus.rdata1);
            end
            checks++;
            if (bus.rdata2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd2[%0d]: got %h expected 00000000", 31 - i, bus.rdata2);
            end
        end
`ifdef REGFILE_WRITE_CNT_EN
        checks++;
        if (wr_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt: got %h expected 00000000", wr_count);
        end
`endif
        bus.we = 1'b0;
        rst    = 1'b1;
        tick();
        bus.raddr1 = 5'd5;
        #1;
        checks++;
        if (bus.rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_drop_x5: got %h expected 00000000", bus.rdata1);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        checks++;
        if (bus.rdata1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_rd_x5: got %h expected deadbeef", bus.rdata1);
        end
        drive(1'b1, 5'd31, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd31);
        #1;
        checks++;
        if (bus.rdata2 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wr_rd_x31: got %h expected 12345678", bus.rdata2);
        end
    endtask

    task automatic test_x0();
        logic [31:0] cnt_before;
        cnt_before = model_cnt;
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        checks++;
        if (bus.rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL x0_same_cycle: got %h expected 00000000", bus.rdata1);
        end
        tick();
        bus.we = 1'b0;
        #1;
        checks++;
        if (bus.rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL x0_after: got %h expected 00000000", bus.rdata2);
        end
`ifdef REGFILE_WRITE_CNT_EN
        checks++;
        if (wr_count !== cnt_before) begin
            errors++;
            $display("FAIL x0_cnt: got %h expected %h", wr_count, cnt_before);
        end
`endif
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 1'b1, 5'd7);
        #1;
        checks++;
        if (bus.rdata1 !== 32'h22 || bus.rdata2 !== 32'h22) begin
            errors++;
            $display("FAIL bypass_pre: got %h/%h expected 00000022/00000022",
                     bus.rdata1, bus.rdata2);
        end
        tick();
        bus.we = 1'b0;
        #1;
        checks++;
        if (bus.rdata1 !== 32'h22 || bus.rdata2 !== 32'h22) begin
            errors++;
            $display("FAIL bypass_post: got %h/%h expected 00000022/00000022",
                     bus.rdata1, bus.rdata2);
        end
    endtask

    task automatic test_read_disable();
        drive(1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b0, 5'd3);
        #1;
        checks++;
        if (bus.rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL rd_disable: got %h expected 00000000", bus.rdata1);
        end
        bus.re1 = 1'b1;
        #1;
        checks++;
        if (bus.rdata1 !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL rd_enable: got %h expected a5a5a5a5", bus.rdata1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd4);
        #1;
        checks++;
        if (bus.rdata1 !== 32'd1 || bus.rdata2 !== 32'd4) begin
            errors++;
            $display("FAIL mid_pre: got %h/%h expected 00000001/00000004",
                     bus.rdata1, bus.rdata2);
        end
`ifdef REGFILE_WRITE_CNT_EN
        checks++;
        if (wr_count !== model_cnt) begin
            errors++;
            $display("FAIL mid_cnt_pre: got %h expected %h", wr_count, model_cnt);
        end
`endif
        // Reset pulse strictly between clock edges.
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL mid_async: got %h/%h expected 0/0", bus.rdata1, bus.rdata2);
        end
`ifdef REGFILE_WRITE_CNT_EN
        checks++;
        if (wr_count !== 32'h0) begin
            errors++;
            $display("FAIL mid_cnt_rst: got %h expected 00000000", wr_count);
        end
`endif
        rst = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            bus.raddr1 = 5'(i);
            #1;
            checks++;
            if (bus.rdata1 !== 32'h0) begin
                errors++;
                $display("FAIL mid_post_x%0d: got %h expected 00000000", i, bus.rdata1);
            end
        end
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        bus.we = 1'b0;
`ifdef REGFILE_WRITE_CNT_EN
        checks++;
        if (wr_count !== 32'd1) begin
            errors++;
            $display("FAIL mid_cnt_one: got %h expected 00000001", wr_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [4:0]  wa;
        logic [31:0] e1;
        logic [31:0] e2;
        for (int n = 0; n < 300; n++) begin
            wa = 5'($urandom_range(0, 31));
            drive(1'($urandom), wa, $urandom,
                  1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
            #1;
            e1 = expect_rd(bus.re1, bus.raddr1);
            e2 = expect_rd(bus.re2, bus.raddr2);
            checks++;
            if (bus.rdata1 !== e1) begin
                errors++;
                $display("FAIL rand_rd1 #%0d addr %0d: got %h expected %h",
                         n, bus.raddr1, bus.rdata1, e1);
            end
            checks++;
            if (bus.rdata2 !== e2) begin
                errors++;
                $display("FAIL rand_rd2 #%0d addr %0d: got %h expected %h",
                         n, bus.raddr2, bus.rdata2, e2);
            end
            tick();
`ifdef REGFILE_WRITE_CNT_EN
            checks++;
            if (wr_count !== model_cnt) begin
                errors++;
                $display("FAIL rand_cnt #%0d: got %h expected %h", n, wr_count, model_cnt);
            end
`endif
        end
        bus.we = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_read_disable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile
